// File: rtl/multicycle_ctrl_if.sv
// Memory bus between the multi-cycle control FSM and the shared instr/data memory.
//   mem_req   : controller requests an access; held until mem_ready
//   mem_we    : access is a write (SW)
//   iord      : address select, 0=PC, 1=ALUOut; stable while mem_req is high
//   mem_ready : memory completes the current request this cycle
// Modports: master = controller side, slave = memory side.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and drives
// the datapath mux selects, enables and ALU funct code. Supports R-type, ADDI, BEQ, BNE, J,
// LW and SW, waits on a memory ready handshake with a watchdog, and parks in a sticky trap
// state on illegal opcodes or watchdog timeouts.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode, funct       IR fields (stable from DECODE until the next fetch completes)
//   zero                ALU result == 0
//   mem                 memory bus (master modport): mem_req, mem_we, iord, mem_ready
//   ir_write, pc_write  IR / PC load enables
//   pc_src              00=ALU result, 01=ALUOut, 10=jump target
//   alu_src_a/alu_src_b ALU operand selects
//   alu_funct           ALU operation (ADD, SUB, or IR funct in EXEC_R)
//   reg_write, rd_mux_s, mem_to_reg   register file write controls
//   retire              pulse on the last cycle of each instruction
//   illegal, fault      sticky trap causes
//   state               current state, for debug
module multicycle_ctrl #(
  parameter bit          EN_BNE    = 1'b1,
  parameter bit          EN_MEM    = 1'b1,
  parameter int unsigned TIMEOUT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [5:0]               opcode,
  input  logic [5:0]               funct,
  input  logic                     zero,
  multicycle_ctrl_if.master        mem,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic [1:0]               pc_src,
  output logic                     alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [5:0]               alu_funct,
  output logic                     reg_write,
  output logic                     rd_mux_s,
  output logic                     mem_to_reg,
  output logic                     retire,
  output logic                     illegal,
  output logic                     fault,
  output logic [3:0]               state
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJump  = 6'b000010;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;

  // Watchdog value at the start of the last wait cycle the limit allows.
  localparam logic [TIMEOUT_W-1:0] WdogLast = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  typedef enum logic [3:0] {
    StRst     = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExecR   = 4'd3,
    StExecI   = 4'd4,
    StBranch  = 4'd5,
    StJump    = 4'd6,
    StMemAddr = 4'd7,
    StMemRd   = 4'd8,
    StMemWr   = 4'd9,
    StWbR     = 4'd10,
    StWbI     = 4'd11,
    StWbMem   = 4'd12,
    StTrap    = 4'd13
  } state_e;

  // Pure state-decoded controls; registered alongside the state they belong to.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [5:0] alu_funct;
    logic       reg_write;
    logic       rd_mux_s;
    logic       mem_to_reg;
    logic       retire;
  } ctl_t;

  function automatic ctl_t ctl_decode(state_e s, logic [5:0] fn);
    ctl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_funct = FnAdd;
      end
      StDecode: begin
        c.alu_src_b = 2'b11;
        c.alu_funct = FnAdd;
      end
      StExecR: begin
        c.alu_src_a = 1'b1;
        c.alu_funct = fn;
      end
      StExecI, StMemAddr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_funct = FnAdd;
      end
      StBranch: begin
        c.alu_src_a = 1'b1;
        c.alu_funct = FnSub;
        c.pc_src    = 2'b01;
        c.retire    = 1'b1;
      end
      StJump: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
        c.retire   = 1'b1;
      end
      StMemRd: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      StMemWr: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      StWbR: begin
        c.reg_write = 1'b1;
        c.rd_mux_s  = 1'b1;
        c.retire    = 1'b1;
      end
      StWbI: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      StWbMem: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.retire     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 illegal_q, illegal_d;
  logic                 fault_q, fault_d;
  ctl_t                 ctl_q;
  logic                 waiting;
  logic                 timeout;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    fault_d   = fault_q;

    waiting = ((state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr)) &&
              !mem.mem_ready;
    // mem_ready on the limit cycle wins because waiting requires it low.
    timeout = waiting && (wdog_q == WdogLast);

    case (state_q)
      StRst: state_d = StFetch;
      StFetch: begin
        if (mem.mem_ready) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StTrap;
          fault_d = 1'b1;
        end
      end
      StDecode: begin
        case (opcode)
          OpRtype:    state_d = StExecR;
          OpAddi:     state_d = StExecI;
          OpBeq:      state_d = StBranch;
          OpBne:      state_d = EN_BNE ? StBranch : StTrap;
          OpJump:     state_d = StJump;
          OpLw, OpSw: state_d = EN_MEM ? StMemAddr : StTrap;
          default:    state_d = StTrap;
        endcase
        illegal_d = (state_d == StTrap);
      end
      StExecR:   state_d = StWbR;
      StExecI:   state_d = StWbI;
      StMemAddr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem.mem_ready) begin
          state_d = StWbMem;
        end else if (timeout) begin
          state_d = StTrap;
          fault_d = 1'b1;
        end
      end
      StMemWr: begin
        if (mem.mem_ready) begin
          state_d = StFetch;
        end else if (timeout) begin
          state_d = StTrap;
          fault_d = 1'b1;
        end
      end
      StBranch, StJump, StWbR, StWbI, StWbMem: state_d = StFetch;
      StTrap:  state_d = StTrap;
      // Unreachable encodings park in TRAP without blaming a cause.
      default: state_d = StTrap;
    endcase

    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (waiting) begin
      wdog_d = wdog_q + TIMEOUT_W'(1);
    end else begin
      wdog_d = wdog_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRst;
      wdog_q    <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      ctl_q     <= '0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
      ctl_q     <= ctl_decode(state_d, funct);
    end
  end

  always_comb begin
    mem.mem_req = ctl_q.mem_req;
    mem.mem_we  = ctl_q.mem_we;
    mem.iord    = ctl_q.iord;
    pc_src      = ctl_q.pc_src;
    alu_src_a   = ctl_q.alu_src_a;
    alu_src_b   = ctl_q.alu_src_b;
    alu_funct   = ctl_q.alu_funct;
    reg_write   = ctl_q.reg_write;
    rd_mux_s    = ctl_q.rd_mux_s;
    mem_to_reg  = ctl_q.mem_to_reg;
    illegal     = illegal_q;
    fault       = fault_q;
    state       = state_q;
    // Handshake- and flag-qualified enables depend on this cycle's inputs.
    ir_write    = (state_q == StFetch) && mem.mem_ready;
    pc_write    = ctl_q.pc_write ||
                  ((state_q == StFetch) && mem.mem_ready) ||
                  ((state_q == StBranch) && ((opcode == OpBne) ? !zero : zero));
    retire      = ctl_q.retire || ((state_q == StMemWr) && mem.mem_ready);
  end

endmodule
